decimator_10x: RTL

- Inverse of the 10x interpolator: consumes one 8-bit sample per clk_en_10x strobe and produces one 8-bit filtered sample per clk_en frame (10:1 decimation).
- 10-tap weighted-sum anti-alias filter, computed with one multiply-accumulate per 10x strobe.
- Sits on the capture path, upstream of 1x-rate logic, sharing the same clk_en / clk_en_10x strobe pair as the interpolator.

---
 rtl/decimator_10x_pkg.sv | 28 ++
 rtl/decimator_10x_if.sv | 30 +++
 rtl/decimator_10x_mac.sv | 21 ++
 rtl/decimator_10x.sv | 130 +++++++++++++
 4 files changed

// File: rtl/decimator_10x_pkg.sv
// Shared constants and helpers for the 10:1 capture-path decimator.
// Default taps form a symmetric window summing to 256 so the filter has unity gain.
package decimator_pkg;

    localparam int NUM_PHASES  = 10;
    localparam int ROUND_CONST = 128;
    localparam int OUT_SHIFT   = 8;
    localparam int PHASE_W     = 4;
    localparam int SAMPLE_W    = 8;
    localparam int PROD_W      = 2 * SAMPLE_W;

    localparam logic [SAMPLE_W-1:0] DEF_COEF0 = 8'h08;
    localparam logic [SAMPLE_W-1:0] DEF_COEF1 = 8'h10;
    localparam logic [SAMPLE_W-1:0] DEF_COEF2 = 8'h1A;
    localparam logic [SAMPLE_W-1:0] DEF_COEF3 = 8'h22;
    localparam logic [SAMPLE_W-1:0] DEF_COEF4 = 8'h2C;
    localparam logic [SAMPLE_W-1:0] DEF_COEF5 = 8'h2C;
    localparam logic [SAMPLE_W-1:0] DEF_COEF6 = 8'h22;
    localparam logic [SAMPLE_W-1:0] DEF_COEF7 = 8'h1A;
    localparam logic [SAMPLE_W-1:0] DEF_COEF8 = 8'h10;
    localparam logic [SAMPLE_W-1:0] DEF_COEF9 = 8'h08;

    // Overridden taps can push the rounded result past 8 bits; clamp instead of wrapping.
    function automatic logic [SAMPLE_W-1:0] sat8(input logic [31:0] value);
        return (value > 32'd255) ? 8'hFF : value[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/decimator_10x_if.sv
// Strobe, sample and status bundle between the capture front end and the decimator.
interface decimator_10x_if;
    import decimator_pkg::*;

    logic                clk_en;
    logic                clk_en_10x;
    logic [SAMPLE_W-1:0] sample_in;
    logic [SAMPLE_W-1:0] sample_out;
    logic                sample_valid;
    logic                overrun;

    modport master (
        output clk_en,
        output clk_en_10x,
        output sample_in,
        input  sample_out,
        input  sample_valid,
        input  overrun
    );

    modport slave (
        input  clk_en,
        input  clk_en_10x,
        input  sample_in,
        output sample_out,
        output sample_valid,
        output overrun
    );

endinterface

// File: rtl/decimator_10x_mac.sv
// One multiply-accumulate step of the decimation filter; load restarts the sum.
module atom_decimator_mac
    import decimator_pkg::*;
#(
    parameter int ACC_W = 20
) (
    input  logic [ACC_W-1:0]    acc_i,
    input  logic [SAMPLE_W-1:0] sample_i,
    input  logic [SAMPLE_W-1:0] coef_i,
    input  logic                load_i,
    output logic [ACC_W-1:0]    acc_o
);

    logic [PROD_W-1:0] product;
    logic [ACC_W-1:0]  product_ext;

    assign product     = PROD_W'(sample_i) * PROD_W'(coef_i);
    assign product_ext = {{(ACC_W-PROD_W){1'b0}}, product};
    assign acc_o       = load_i ? product_ext : (acc_i + product_ext);

endmodule

// File: rtl/decimator_10x.sv
// 10:1 decimator: one MAC per 10x strobe, one rounded and saturated output per frame.
// A clk_en arriving mid-frame aborts the partial sum and starts a new frame on that sample.
module decimator_10x
    import decimator_pkg::*;
#(
    parameter logic [7:0] COEF0 = DEF_COEF0,
    parameter logic [7:0] COEF1 = DEF_COEF1,
    parameter logic [7:0] COEF2 = DEF_COEF2,
    parameter logic [7:0] COEF3 = DEF_COEF3,
    parameter logic [7:0] COEF4 = DEF_COEF4,
    parameter logic [7:0] COEF5 = DEF_COEF5,
    parameter logic [7:0] COEF6 = DEF_COEF6,
    parameter logic [7:0] COEF7 = DEF_COEF7,
    parameter logic [7:0] COEF8 = DEF_COEF8,
    parameter logic [7:0] COEF9 = DEF_COEF9,
    parameter int         ACC_W = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    decimator_10x_if.slave   bus
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;
    localparam int         RND_W    = ACC_W + 1;

    logic [0:0]          state_q, state_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [SAMPLE_W-1:0] out_q, out_d;
    logic                valid_q, valid_d;
    logic                overrun_q, overrun_d;

    logic                start_frame;
    logic                accum_step;
    logic                last_phase;
    logic [PHASE_W-1:0]  coef_idx;
    logic [SAMPLE_W-1:0] coef;
    logic [ACC_W-1:0]    mac_acc;
    logic [RND_W-1:0]    rounded;

    assign start_frame = bus.clk_en_10x && bus.clk_en;
    assign accum_step  = bus.clk_en_10x && !bus.clk_en && (state_q == ST_ACCUM);
    assign last_phase  = (phase_q == PHASE_W'(NUM_PHASES - 1));

    // A frame start always weights its sample with tap 0, even when it interrupts a frame.
    assign coef_idx = start_frame ? '0 : phase_q;

    always_comb begin
        coef = 8'h00;
        case (coef_idx)
            4'd0:    coef = COEF0;
            4'd1:    coef = COEF1;
            4'd2:    coef = COEF2;
            4'd3:    coef = COEF3;
            4'd4:    coef = COEF4;
            4'd5:    coef = COEF5;
            4'd6:    coef = COEF6;
            4'd7:    coef = COEF7;
            4'd8:    coef = COEF8;
            4'd9:    coef = COEF9;
            default: coef = 8'h00;
        endcase
    end

    atom_decimator_mac #(
        .ACC_W (ACC_W)
    ) u_mac (
        .acc_i    (acc_q),
        .sample_i (bus.sample_in),
        .coef_i   (coef),
        .load_i   (start_frame),
        .acc_o    (mac_acc)
    );

    assign rounded = ({1'b0, mac_acc} + RND_W'(ROUND_CONST)) >> OUT_SHIFT;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        acc_d     = acc_q;
        out_d     = out_q;
        valid_d   = 1'b0;
        overrun_d = 1'b0;
        if (start_frame) begin
            acc_d     = mac_acc;
            phase_d   = PHASE_W'(1);
            state_d   = ST_ACCUM;
            overrun_d = (state_q == ST_ACCUM);
        end else if (accum_step) begin
            if (last_phase) begin
                out_d   = sat8(32'(rounded));
                valid_d = 1'b1;
                state_d = ST_IDLE;
                phase_d = '0;
                acc_d   = '0;
            end else begin
                acc_d   = mac_acc;
                phase_d = phase_q + PHASE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            acc_q     <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            acc_q     <= acc_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.sample_out   = out_q;
    assign bus.sample_valid = valid_q;
    assign bus.overrun      = overrun_q;

    a_valid_overrun_exclusive: assert property (
        @(posedge clk) disable iff (!reset_n) !(valid_q && overrun_q)
    );

endmodule
